// File: rtl/mul_job_sched.sv
// Job scheduler for the dense BRAM multiplier: queues tagged jobs, steers bank muxes,
// runs the multiplier with a watchdog and returns in-order tagged completions.
module mul_job_sched #(
   parameter int              BANK_SEL_W = 2,
   parameter int              TAG_W      = 4,
   parameter int              FIFO_DEPTH = 4,
   parameter int              TO_W       = 17,
   parameter logic [TO_W-1:0] TIMEOUT    = 17'd100000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  job_valid,
   output logic                  job_ready,
   input  logic [BANK_SEL_W-1:0] job_op0,
   input  logic [BANK_SEL_W-1:0] job_op1,
   input  logic [BANK_SEL_W-1:0] job_re,
   input  logic [TAG_W-1:0]      job_tag,
   output logic [BANK_SEL_W-1:0] op0_sel,
   output logic [BANK_SEL_W-1:0] op1_sel,
   output logic [BANK_SEL_W-1:0] re_sel,
   output logic                  mul_start,
   input  logic                  mul_done,
   output logic                  mul_rst_b,
   output logic                  busy,
   output logic                  cmpl_valid,
   input  logic                  cmpl_ready,
   output logic [TAG_W-1:0]      cmpl_tag,
   output logic [1:0]            cmpl_err
);

   localparam int              AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [AW:0]     FULL_CNT = (AW+1)'(FIFO_DEPTH);
   localparam logic [TO_W-1:0] WD_LAST  = TIMEOUT - 1'b1;

   typedef struct packed {
      logic [TAG_W-1:0]      tag;
      logic [BANK_SEL_W-1:0] re;
      logic [BANK_SEL_W-1:0] op1;
      logic [BANK_SEL_W-1:0] op0;
   } job_t;

   typedef enum logic [2:0] {IDLE, CFG, START, WAIT, CMPL, RECOV} state_t;

   job_t            mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [AW:0]     count;
   job_t            job;
   state_t          state;
   logic [TO_W-1:0] wd;
   logic            done_q, done_qq, mrst_cnt;
   logic            push, pop, done_edge, aliased;

   assign job_ready = (count != FULL_CNT);
   assign push      = job_valid & job_ready;
   assign pop       = (state == IDLE) && (count != '0) && mul_rst_b;
   assign done_edge = done_q & ~done_qq;
   assign aliased   = (job.re == job.op0) || (job.re == job.op1);
   assign busy      = (state != IDLE) || (count != '0);

   // NOTE: FIFO storage has no reset; the pointers and count alone define its contents.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {job_tag, job_re, job_op1, job_op0};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         job        <= '0;
         op0_sel    <= '0;
         op1_sel    <= '0;
         re_sel     <= '0;
         mul_start  <= 1'b0;
         mul_rst_b  <= 1'b0;
         mrst_cnt   <= 1'b0;
         wd         <= '0;
         done_q     <= 1'b0;
         done_qq    <= 1'b0;
         cmpl_valid <= 1'b0;
         cmpl_tag   <= '0;
         cmpl_err   <= 2'b00;
      end else begin
         // Edge detector tracks mul_done in every state so a level held across START is not an edge.
         done_q    <= mul_done;
         done_qq   <= done_q;
         mul_start <= 1'b0;
         // Multiplier reset is always released on the second cycle it has been low.
         if (!mul_rst_b) begin
            mrst_cnt <= ~mrst_cnt;
            if (mrst_cnt) mul_rst_b <= 1'b1;
         end
         case (state)
            IDLE: if (pop) begin
               job     <= mem[rd_ptr];
               op0_sel <= mem[rd_ptr].op0;
               op1_sel <= mem[rd_ptr].op1;
               re_sel  <= mem[rd_ptr].re;
               state   <= CFG;
            end
            CFG: if (aliased) begin
               cmpl_err   <= 2'b01;
               cmpl_tag   <= job.tag;
               cmpl_valid <= 1'b1;
               state      <= CMPL;
            end else begin
               mul_start <= 1'b1;
               state     <= START;
            end
            START: begin
               wd    <= '0;
               state <= WAIT;
            end
            WAIT: begin
               wd <= wd + 1'b1;
               if (done_edge) begin
                  cmpl_err   <= 2'b00;
                  cmpl_tag   <= job.tag;
                  cmpl_valid <= 1'b1;
                  state      <= CMPL;
               end else if (wd == WD_LAST) begin
                  cmpl_err  <= 2'b10;
                  mul_rst_b <= 1'b0;
                  mrst_cnt  <= 1'b0;
                  state     <= RECOV;
               end
            end
            RECOV: if (mrst_cnt) begin
               cmpl_tag   <= job.tag;
               cmpl_valid <= 1'b1;
               state      <= CMPL;
            end
            CMPL: if (cmpl_ready) begin
               cmpl_valid <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_job_sched.sv
// Scoreboard bench for mul_job_sched: random and directed jobs against a queue-based reference model.
module tb_mul_job_sched;
   localparam int BW = 2;
   localparam int TW = 4;
   localparam int TO = 20;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          job_valid = 1'b0;
   logic          job_ready;
   logic [BW-1:0] job_op0 = '0, job_op1 = '0, job_re = '0;
   logic [TW-1:0] job_tag = '0;
   logic [BW-1:0] op0_sel, op1_sel, re_sel;
   logic          mul_start;
   logic          mul_done = 1'b0;
   logic          mul_rst_b, busy, cmpl_valid;
   logic          cmpl_ready = 1'b1;
   logic [TW-1:0] cmpl_tag;
   logic [1:0]    cmpl_err;

   mul_job_sched #(.BANK_SEL_W(BW), .TAG_W(TW), .FIFO_DEPTH(4), .TO_W(17), .TIMEOUT(17'd20)) dut (
      .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
      .job_op0(job_op0), .job_op1(job_op1), .job_re(job_re), .job_tag(job_tag),
      .op0_sel(op0_sel), .op1_sel(op1_sel), .re_sel(re_sel),
      .mul_start(mul_start), .mul_done(mul_done), .mul_rst_b(mul_rst_b), .busy(busy),
      .cmpl_valid(cmpl_valid), .cmpl_ready(cmpl_ready), .cmpl_tag(cmpl_tag), .cmpl_err(cmpl_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [BW-1:0] op0, op1, re;
      logic [TW-1:0] tag;
      bit            hang;
      int            dly;
   } job_t;
   typedef struct {
      logic [TW-1:0] tag;
      logic [1:0]    err;
   } exp_t;

   exp_t exp_q[$];
   job_t start_q[$];
   int   n_cmp = 0, n_bad = 0;
   int   cyc = 0, done_cyc = 0;
   int   rmode = 0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic fail(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // Reference: aliasing banks are rejected, a multiplier that never answers times out.
   function automatic exp_t model(input job_t j);
      exp_t e;
      e.tag = j.tag;
      if (j.re == j.op0 || j.re == j.op1) e.err = 2'b01;
      else if (j.hang)                    e.err = 2'b10;
      else                                e.err = 2'b00;
      return e;
   endfunction

   function automatic job_t mk(input int op0, input int op1, input int re, input int tag,
                               input bit hang, input int dly);
      job_t j;
      j.op0 = BW'(op0); j.op1 = BW'(op1); j.re = BW'(re); j.tag = TW'(tag);
      j.hang = hang; j.dly = dly;
      return j;
   endfunction

   task automatic push_job(input job_t j);
      exp_t e;
      @(negedge clk);
      job_valid = 1'b1;
      job_op0 = j.op0; job_op1 = j.op1; job_re = j.re; job_tag = j.tag;
      for (int i = 0; i < 3000 && !job_ready; i++) @(negedge clk);
      if (!job_ready) fail("push_timeout");
      else begin
         e = model(j);
         exp_q.push_back(e);
         if (e.err != 2'b01) start_q.push_back(j);
      end
      @(negedge clk);
      job_valid = 1'b0;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 5000 && (exp_q.size() != 0 || busy); i++) @(negedge clk);
      if (exp_q.size() != 0 || busy) fail("drain_timeout");
   endtask

   task automatic check_reset_vals();
      check("rst_job_ready", job_ready, 1);
      check("rst_mul_rst_b", mul_rst_b, 0);
      check("rst_busy", busy, 0);
      check("rst_cmpl_valid", cmpl_valid, 0);
      check("rst_mul_start", mul_start, 0);
      check("rst_sels", {op0_sel, op1_sel, re_sel}, 0);
      check("rst_cmpl_tag_err", {cmpl_tag, cmpl_err}, 0);
   endtask

   task automatic check_release();
      @(negedge clk);
      check("mrst_after_1_edge", mul_rst_b, 0);
      @(negedge clk);
      check("mrst_after_2_edges", mul_rst_b, 1);
   endtask

   // Completion acceptance pattern.
   initial forever begin
      @(posedge clk);
      #1;
      case (rmode)
         0:       cmpl_ready = 1'b1;
         1:       cmpl_ready = 1'($urandom_range(0, 1));
         default: cmpl_ready = 1'b0;
      endcase
   end

   // Multiplier model: answers each start after the job's delay, or never for hung jobs.
   initial begin
      job_t j;
      bit   act = 0, hang = 0;
      int   dcnt = 0, dly = 0, hang_cnt = 0, low_w = 0;
      forever begin
         @(negedge clk);
         mul_done = 1'b0;
         if (rst) begin
            act = 0; hang = 0;
            continue;
         end
         if (mul_start) begin
            check("start_while_cmpl", cmpl_valid, 0);
            if (start_q.size() == 0) fail("unexpected_start");
            else begin
               j = start_q.pop_front();
               check("op0_sel", op0_sel, j.op0);
               check("op1_sel", op1_sel, j.op1);
               check("re_sel", re_sel, j.re);
               hang = j.hang; act = !j.hang; dly = j.dly;
               dcnt = 0; hang_cnt = 0; low_w = 0;
            end
         end else if (act) begin
            dcnt++;
            if (dcnt == dly) begin
               mul_done = 1'b1;
               done_cyc = cyc;
               act = 0;
            end
         end else if (hang) begin
            hang_cnt++;
            if (!mul_rst_b) begin
               if (low_w == 0) check("timeout_delay_in_window", (hang_cnt >= TO && hang_cnt <= TO + 1), 1);
               low_w++;
            end else if (low_w > 0) begin
               check("recov_low_width", low_w, 2);
               hang = 0;
            end else if (hang_cnt > TO + 5) begin
               fail("timeout_never_fired");
               hang = 0;
            end
         end
      end
   end

   // Completion monitor.
   initial begin
      exp_t          e;
      bit            pv = 0, hold = 0;
      logic [TW-1:0] ptag = '0;
      logic [1:0]    perr = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            pv = 0; hold = 0;
            continue;
         end
         if (cmpl_valid) begin
            if (!pv && exp_q.size() == 0) fail("stale_completion");
            if (!pv && exp_q.size() != 0 && exp_q[0].err == 2'b00)
               check("done_to_cmpl_cycles", cyc - done_cyc, 2);
            if (hold) begin
               check("bp_tag_stable", cmpl_tag, ptag);
               check("bp_err_stable", cmpl_err, perr);
            end
            if (cmpl_ready && exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("cmpl_tag", cmpl_tag, e.tag);
               check("cmpl_err", cmpl_err, e.err);
            end
            hold = !cmpl_ready; ptag = cmpl_tag; perr = cmpl_err;
         end else if (hold) begin
            fail("bp_valid_dropped");
            hold = 0;
         end
         pv = cmpl_valid;
      end
   end

   initial begin
      job_t j;
      #2;
      check_reset_vals();
      @(negedge clk);
      rst = 1'b0;
      check_release();

      push_job(mk(0, 1, 2, 5, 0, 10));
      wait_drain();
      push_job(mk(0, 1, 1, 3, 0, 1));
      wait_drain();

      // Fill with the FSM parked in CMPL, then hold the completion for 30 cycles.
      rmode = 2;
      push_job(mk(0, 1, 2, 0, 0, 3));
      for (int i = 0; i < 200 && !cmpl_valid; i++) @(negedge clk);
      check("first_cmpl_seen", cmpl_valid, 1);
      for (int t = 1; t <= 4; t++) push_job(mk(t % 4, (t + 1) % 4, (t + 2) % 4, t, 0, t + 2));
      check("full_ready_low", job_ready, 0);
      @(negedge clk);
      job_valid = 1'b1; job_tag = 4'd9;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (i < 5) check("fifth_stalled", job_ready, 0);
      end
      job_valid = 1'b0;
      rmode = 0;
      wait_drain();

      push_job(mk(0, 1, 3, 7, 1, 0));
      push_job(mk(2, 3, 0, 8, 0, 4));
      wait_drain();

      rmode = 1;
      for (int i = 0; i < 40; i++) begin
         j = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), i,
                $urandom_range(0, 7) == 0, $urandom_range(1, 15));
         push_job(j);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_drain();
      rmode = 0;

      // Reset while the first job is stuck in WAIT with two more queued.
      push_job(mk(0, 1, 2, 10, 1, 0));
      push_job(mk(1, 2, 3, 11, 0, 5));
      push_job(mk(2, 3, 0, 12, 0, 5));
      for (int i = 0; i < 100 && !mul_start; i++) @(negedge clk);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      check_reset_vals();
      exp_q.delete();
      start_q.delete();
      @(negedge clk);
      rst = 1'b0;
      check_release();
      repeat (20) @(negedge clk);
      check("post_reset_busy", busy, 0);
      push_job(mk(3, 0, 1, 13, 0, 6));
      wait_drain();

      check("final_exp_empty", exp_q.size(), 0);
      check("final_start_empty", start_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/mul_job_sched.md
Name: mul_job_sched

Overview:
- Job scheduler in front of the dense BRAM multiplier controller in the BIKE KeyGen datapath.
- Accepts multiplication jobs (op0 bank, op1 bank, result bank, tag) into a small FIFO.
- For each job: steers the bank muxes, pulses the multiplier start, waits for its done pulse, then returns a tagged completion.
- Recovers a hung multiplier via watchdog and a multiplier-local reset.

Parameters:
BANK_SEL_W, 2, width of bank select; up to 4 BRAM banks
TAG_W, 4, job tag width
FIFO_DEPTH, 4, job FIFO entries (power of 2)
TO_W, 17, watchdog counter width
TIMEOUT, 17'd100000, cycles in WAIT before abort; must be < 2^TO_W

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
job_valid  in  1  job offered
job_ready  out  1  FIFO not full
job_op0  in  BANK_SEL_W  bank for operand 0
job_op1  in  BANK_SEL_W  bank for operand 1
job_re  in  BANK_SEL_W  bank for result
job_tag  in  TAG_W  job identifier
op0_sel  out  BANK_SEL_W  operand-0 bank mux select
op1_sel  out  BANK_SEL_W  operand-1 bank mux select
re_sel  out  BANK_SEL_W  result bank mux select
mul_start  out  1  one-cycle start pulse to multiplier
mul_done  in  1  multiplier done (nominally one-cycle high)
mul_rst_b  out  1  active-low synchronous reset to multiplier
busy  out  1  FSM not IDLE or FIFO not empty
cmpl_valid  out  1  completion available
cmpl_ready  in  1  completion accepted
cmpl_tag  out  TAG_W  tag of completed job
cmpl_err  out  2  00 ok, 01 alias reject, 10 timeout

Behaviour:
- Reset (async, any state): FIFO empty, FSM IDLE. All outputs 0 except job_ready=1 and mul_rst_b=0. After rst falls, mul_rst_b stays 0 for 2 more clk edges, then goes 1. Jobs may be pushed during this window; no pop until mul_rst_b=1.
- Push rule: push when job_valid & job_ready. job_ready = !full, from the registered count. No bypass: a push into an empty FIFO is visible to IDLE the next cycle. Push and pop in the same cycle are allowed; count is unchanged.
- FSM states: IDLE, CFG, START, WAIT, CMPL, RECOV.
- IDLE:
  - If FIFO non-empty and mul_rst_b=1: pop the head into the job register, drive op0_sel/op1_sel/re_sel from it, go to CFG.
  - Selects hold their last value between jobs.
- CFG (one settle cycle for the muxes):
  - If job_re equals job_op0 or job_op1: cmpl_err=01, go to CMPL; multiplier not started.
  - Otherwise go to START.
- START: mul_start=1 for exactly this cycle. Clear the watchdog. Go to WAIT.
- WAIT:
  - Watchdog increments each cycle.
  - Rising edge of mul_done (registered edge detect): cmpl_err=00, go to CMPL.
  - Else if watchdog==TIMEOUT-1: cmpl_err=10, drive mul_rst_b=0, go to RECOV.
  - A done edge and the timeout in the same cycle resolve as done/ok.
- RECOV: mul_rst_b held 0 for 2 cycles total, then 1. Go to CMPL.
- CMPL:
  - cmpl_valid=1; cmpl_tag and cmpl_err stable until cmpl_ready.
  - On cmpl_valid & cmpl_ready: cmpl_valid=0 next cycle, go to IDLE.
  - If cmpl_ready is already high on the first CMPL cycle, that is a one-cycle handshake.
- mul_done outside WAIT is ignored, but the edge-detect register still tracks it, so a level held high across START does not count as a new edge.
- Minimum per-job overhead, pop to cmpl_valid, excluding multiplier time: IDLE→CFG→START→WAIT(≥2)→CMPL.
- busy = (state != IDLE) | !empty.
- Completions are strictly in push order. FIFO pointers wrap modulo FIFO_DEPTH.

Test Plan:
- Single job op0=0, op1=1, re=2, tag=5; mul_done pulses 10 cycles after mul_start → exactly one mul_start pulse; op0_sel=0, op1_sel=1, re_sel=2 from CFG onward; cmpl_valid with tag=5, err=00 two cycles after the done pulse.
- Alias: push re=1, op1=1, tag=3 → no mul_start; completion tag=3, err=01 two cycles after pop.
- Back-to-back: push 5 jobs with tags 0–4 and no pops → job_ready=0 after the 4th push, 5th stalled; completions in order 0..4 with cmpl_ready always 1.
- Timeout: TIMEOUT=20, mul_done never asserted → mul_rst_b low for 2 cycles, 20 cycles after mul_start; completion err=10; next queued job then starts normally.
- Backpressure: hold cmpl_ready=0 for 30 cycles → cmpl_valid, tag and err stable; no next mul_start until acceptance.
- Reset mid-WAIT with 2 jobs queued → all outputs at reset values immediately; FIFO empty; mul_rst_b rises 2 clocks after rst falls; no stale completion appears.
